// File: rtl/deser16_1.sv
//------------------------------------------------------------------------------
// deser16_1 : LSB-first 16:1 deserializer with valid/ready handshakes on both sides
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module deser16_1 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CNT_W-1:0] pos,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        if (clear) begin
            state_d = COLLECT;
            cnt_d   = '0;
            word_d  = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        word_d[cnt_q] = in_bit;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Word is zeroed on hand-off so partial words read 0 above pos.
                    if (out_ready) begin
                        state_d = COLLECT;
                        word_d  = '0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign pos       = cnt_q;
    assign out_word  = word_q;

endmodule

`default_nettype wire

// File: tb/tb_deser16_1.sv
//------------------------------------------------------------------------------
// tb_deser16_1 : directed self-checking bench for deser16_1 with a word scoreboard
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_deser16_1;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  pos;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] sb_q[$];

    deser16_1 #(.WIDTH(16), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pos       (pos),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_iready"}, 32'(in_ready), 32'd1);
        chk({tag, "_pos"}, 32'(pos), 32'd0);
        chk({tag, "_word"}, 32'(out_word), 32'd0);
    endtask

    // Stream one word LSB first, optionally with a one-cycle gap before each bit after the first.
    task automatic send_word(input logic [15:0] w, input bit gaps);
        logic [16:0] mask;
        sb_q.push_back(w);
        for (int i = 0; i < 16; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                tick();
                chk("gap_pos", 32'(pos), 32'(i));
            end
            chk("pre_pos", 32'(pos), 32'(i));
            chk("pre_iready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_bit   = w[i];
            tick();
            mask = (17'h1 << (i + 1)) - 17'h1;
            chk("partial_word", 32'(out_word), 32'(w & mask[15:0]));
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag);
        logic [15:0] e;
        chk({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        chk({tag, "_iready"}, 32'(in_ready), 32'd0);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_sb: observed output %h expected no word", tag, out_word);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_word"}, 32'(out_word), 32'(e));
        end
    endtask

    task automatic take_word(input string tag);
        expect_word(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle({tag, "_after"});
    endtask

    initial begin
        logic [15:0] words [3];
        reset     = 1'b0;
        clear     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        #3;
        chk_idle("reset");
        #9 reset = 1'b1;
        tick();
        chk_idle("post_reset");

        // Continuous stream, single bit set.
        send_word(16'h0800, 1'b0);
        take_word("w0800");

        // Gapped stream.
        send_word(16'h0080, 1'b1);
        take_word("w0080");

        // Stall in HOLD with in_valid asserted.
        send_word(16'hA5C3, 1'b0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_iready", 32'(in_ready), 32'd0);
            chk("hold_ovalid", 32'(out_valid), 32'd1);
            chk("hold_word", 32'(out_word), 32'h0000A5C3);
        end
        in_valid = 1'b0;
        take_word("wA5C3");
        send_word(16'h0001, 1'b0);
        take_word("w0001");

        // Abort a partial word with clear; the bit presented alongside clear is dropped.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
        end
        chk("pre_clear_pos", 32'(pos), 32'd7);
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk_idle("clear");
        send_word(16'h1234, 1'b0);
        take_word("w1234");

        // Asynchronous reset mid-word.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_idle("async_reset");
        #2 reset = 1'b1;
        tick();
        chk_idle("reset_release");
        send_word(16'h0000, 1'b0);
        take_word("w0000");
        send_word(16'hFFFF, 1'b0);
        take_word("wFFFF");

        // Back-to-back with out_ready tied high: one-cycle HOLD, then one bubble.
        words[0]  = 16'h0001;
        words[1]  = 16'h8000;
        words[2]  = 16'hFFFF;
        out_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            sb_q.push_back(words[w]);
            for (int i = 0; i < 16; i++) begin
                chk("b2b_pos", 32'(pos), 32'(i));
                chk("b2b_iready", 32'(in_ready), 32'd1);
                in_valid = 1'b1;
                in_bit   = words[w][i];
                tick();
            end
            expect_word("b2b");
            in_bit = (w < 2) ? words[w + 1][0] : 1'b0;
            in_valid = (w < 2);
            tick();
            chk("b2b_bubble_ovalid", 32'(out_valid), 32'd0);
            chk("b2b_bubble_pos", 32'(pos), 32'd0);
            chk("b2b_bubble_word", 32'(out_word), 32'd0);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;

        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
